// File: rtl/multicycle_ctrl_ws.sv
// Multicycle CPU control unit: fetch/decode/execute/writeback sequencing with a
// req/ready memory handshake, a bus timeout, an illegal-type halt and a
// saturating count of retired instructions.
module multicycle_ctrl_ws #(
    parameter int TYPE_W  = 3,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TYPE_W-1:0] ins_type,
    input  logic              ins_l,
    input  logic              ins_i,
    input  logic              cond_ok,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_adr,
    output logic              ir_write,
    output logic              pc_write,
    output logic              pc_src,
    output logic              reg_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        alu_op,
    output logic              flag_write,
    output logic              busy,
    output logic              halted,
    output logic              bus_err,
    output logic [CNT_W-1:0]  instr_cnt
);

    localparam int TO_W = $clog2(TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MADDR,
        S_MACC, S_MWB, S_BRANCH, S_HALT, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wait_st, expired, retire;

    assign instr_cnt = cnt_q;

    // State, timeout counter and retire counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            to_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state plus control decode; only the handshake and branch/ALU
    // qualifiers named per state reach the outputs combinationally.
    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_adr    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        flag_write = 1'b0;
        busy       = 1'b1;
        halted     = 1'b0;
        bus_err    = 1'b0;

        wait_st = (state_q == S_FETCH) || (state_q == S_MACC);
        // A ready on the final allowed cycle still completes normally.
        expired = wait_st && !mem_ready && (to_q == TO_W'(TIMEOUT - 1));

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (expired) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                if (ins_type == TYPE_W'(0))      state_d = S_EXEC;
                else if (ins_type == TYPE_W'(1)) state_d = S_MADDR;
                else if (ins_type == TYPE_W'(2)) state_d = S_BRANCH;
                else                             state_d = S_HALT;
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = ins_i ? 2'd2 : 2'd0;
                alu_op     = 2'd1;
                flag_write = 1'b1;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = S_MACC;
            end
            S_MACC: begin
                mem_req = 1'b1;
                mem_adr = 1'b1;
                mem_we  = ~ins_l;
                if (mem_ready) begin
                    if (ins_l) begin
                        state_d = S_MWB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (expired) begin
                    state_d = S_ERR;
                end
            end
            S_MWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                pc_write  = cond_ok;
                pc_src    = cond_ok;
                reg_write = cond_ok & ins_l;
                reg_dst   = cond_ok & ins_l;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            S_ERR: begin
                busy    = 1'b0;
                bus_err = 1'b1;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Timeout: restart on every state change, count idle wait cycles.
    always_comb begin
        to_d = to_q;
        if (state_d != state_q)       to_d = '0;
        else if (wait_st && !mem_ready) to_d = to_q + TO_W'(1);
    end

    // Retired-instruction counter, saturating at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (retire && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

endmodule

// File: tb/tb_multicycle_ctrl_ws.sv
// Directed bench for multicycle_ctrl_ws. Control outputs are packed into one
// vector ctl = {mem_req,mem_we,mem_adr,ir_write,pc_write,pc_src,reg_write,
// reg_dst,mem_to_reg,alu_src_a,alu_src_b[1:0],alu_op[1:0],flag_write,busy,
// halted,bus_err} and compared against hand-written per-state constants.
module tb_multicycle_ctrl_ws;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [2:0] ins_type = 3'd0;
    logic ins_l = 1'b0, ins_i = 1'b0, cond_ok = 1'b0, mem_ready = 1'b0;

    logic mem_req, mem_we, mem_adr, ir_write, pc_write, pc_src, reg_write;
    logic reg_dst, mem_to_reg, alu_src_a, flag_write, busy, halted, bus_err;
    logic [1:0] alu_src_b, alu_op;
    logic [15:0] instr_cnt;

    logic s_mem_req, s_mem_we, s_mem_adr, s_ir_write, s_pc_write, s_pc_src, s_reg_write;
    logic s_reg_dst, s_mem_to_reg, s_alu_src_a, s_flag_write, s_busy, s_halted, s_bus_err;
    logic [1:0] s_alu_src_b, s_alu_op;
    logic [1:0] s_instr_cnt;

    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_ws #(.TYPE_W(3), .TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .ins_type(ins_type), .ins_l(ins_l),
        .ins_i(ins_i), .cond_ok(cond_ok), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .flag_write(flag_write), .busy(busy), .halted(halted),
        .bus_err(bus_err), .instr_cnt(instr_cnt)
    );

    // Narrow-counter copy sharing the same stimulus, for saturation.
    multicycle_ctrl_ws #(.TYPE_W(3), .TIMEOUT(16), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .ins_type(ins_type), .ins_l(ins_l),
        .ins_i(ins_i), .cond_ok(cond_ok), .mem_ready(mem_ready),
        .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_adr(s_mem_adr), .ir_write(s_ir_write),
        .pc_write(s_pc_write), .pc_src(s_pc_src), .reg_write(s_reg_write), .reg_dst(s_reg_dst),
        .mem_to_reg(s_mem_to_reg), .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b),
        .alu_op(s_alu_op), .flag_write(s_flag_write), .busy(s_busy), .halted(s_halted),
        .bus_err(s_bus_err), .instr_cnt(s_instr_cnt)
    );

    logic [17:0] ctl;
    assign ctl = {mem_req, mem_we, mem_adr, ir_write, pc_write, pc_src, reg_write,
                  reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, flag_write,
                  busy, halted, bus_err};

    //                            rq we ad ir pw ps rw rd mr sa sb op fw by ht be
    localparam logic [17:0] C_IDLE  = 18'b0_0_0_0_0_0_0_0_0_0_00_00_0_0_0_0;
    localparam logic [17:0] C_FWAIT = 18'b1_0_0_0_0_0_0_0_0_0_01_00_0_1_0_0;
    localparam logic [17:0] C_FRDY  = 18'b1_0_0_1_1_0_0_0_0_0_01_00_0_1_0_0;
    localparam logic [17:0] C_DEC   = 18'b0_0_0_0_0_0_0_0_0_0_11_00_0_1_0_0;
    localparam logic [17:0] C_EXR   = 18'b0_0_0_0_0_0_0_0_0_1_00_01_1_1_0_0;
    localparam logic [17:0] C_EXI   = 18'b0_0_0_0_0_0_0_0_0_1_10_01_1_1_0_0;
    localparam logic [17:0] C_AWB   = 18'b0_0_0_0_0_0_1_0_0_0_00_00_0_1_0_0;
    localparam logic [17:0] C_MADR  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_0_1_0_0;
    localparam logic [17:0] C_MLD   = 18'b1_0_1_0_0_0_0_0_0_0_00_00_0_1_0_0;
    localparam logic [17:0] C_MST   = 18'b1_1_1_0_0_0_0_0_0_0_00_00_0_1_0_0;
    localparam logic [17:0] C_MWB   = 18'b0_0_0_0_0_0_1_0_1_0_00_00_0_1_0_0;
    localparam logic [17:0] C_BRL   = 18'b0_0_0_0_1_1_1_1_0_0_00_00_0_1_0_0;
    localparam logic [17:0] C_BRN   = 18'b0_0_0_0_0_0_0_0_0_0_00_00_0_1_0_0;
    localparam logic [17:0] C_HALT  = 18'b0_0_0_0_0_0_0_0_0_0_00_00_0_0_1_0;
    localparam logic [17:0] C_ERR   = 18'b0_0_0_0_0_0_0_0_0_0_00_00_0_0_0_1;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; mem_ready = 1'b0;
        ins_type = 3'd0; ins_l = 1'b0; ins_i = 1'b0; cond_ok = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        ntot++; if (ctl !== C_IDLE) $display("FAIL reset_ctl: got %b exp %b", ctl, C_IDLE); else npass++;
        ntot++; if (instr_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d exp 0", instr_cnt); else npass++;
        do_reset();
        step();
        ntot++; if (ctl !== C_IDLE) $display("FAIL idle_no_start: got %b exp %b", ctl, C_IDLE); else npass++;
    endtask

    task automatic test_alu();
        start = 1'b1;
        step(); start = 1'b0; mem_ready = 1'b1; ins_type = 3'd0; ins_i = 1'b0; #1;
        ntot++; if (ctl !== C_FRDY) $display("FAIL alu_fetch: got %b exp %b", ctl, C_FRDY); else npass++;
        step(); mem_ready = 1'b0; #1;
        ntot++; if (ctl !== C_DEC) $display("FAIL alu_decode: got %b exp %b", ctl, C_DEC); else npass++;
        step(); #1;
        ntot++; if (ctl !== C_EXR) $display("FAIL alu_exec: got %b exp %b", ctl, C_EXR); else npass++;
        step(); #1;
        ntot++; if (ctl !== C_AWB) $display("FAIL alu_wb: got %b exp %b", ctl, C_AWB); else npass++;
        step(); #1;
        ntot++; if (ctl !== C_FWAIT) $display("FAIL alu_refetch: got %b exp %b", ctl, C_FWAIT); else npass++;
        ntot++; if (instr_cnt !== 16'd1) $display("FAIL alu_cnt: got %0d exp 1", instr_cnt); else npass++;
        // Immediate-operand variant
        mem_ready = 1'b1; ins_i = 1'b1; step(); mem_ready = 1'b0; step(); #1;
        ntot++; if (ctl !== C_EXI) $display("FAIL alu_exec_imm: got %b exp %b", ctl, C_EXI); else npass++;
        step(); step(); #1;
        ntot++; if (instr_cnt !== 16'd2) $display("FAIL alu_imm_cnt: got %0d exp 2", instr_cnt); else npass++;
        ins_i = 1'b0;
    endtask

    task automatic test_load();
        int reqs = 0;
        mem_ready = 1'b1; ins_type = 3'd1; ins_l = 1'b1; #1;
        ntot++; if (ctl !== C_FRDY) $display("FAIL ld_fetch: got %b exp %b", ctl, C_FRDY); else npass++;
        step(); mem_ready = 1'b0; #1;
        step(); #1;
        ntot++; if (ctl !== C_MADR) $display("FAIL ld_maddr: got %b exp %b", ctl, C_MADR); else npass++;
        for (int k = 0; k < 4; k++) begin
            step(); mem_ready = (k == 3); #1;
            ntot++; if (ctl !== C_MLD) $display("FAIL ld_macc%0d: got %b exp %b", k, ctl, C_MLD); else npass++;
            if (mem_req) reqs++;
        end
        ntot++; if (reqs !== 4) $display("FAIL ld_req_cycles: got %0d exp 4", reqs); else npass++;
        step(); mem_ready = 1'b0; #1;
        ntot++; if (ctl !== C_MWB) $display("FAIL ld_mwb: got %b exp %b", ctl, C_MWB); else npass++;
        step(); #1;
        ntot++; if (instr_cnt !== 16'd3) $display("FAIL ld_cnt: got %0d exp 3", instr_cnt); else npass++;
    endtask

    task automatic test_store_branch();
        mem_ready = 1'b1; ins_type = 3'd1; ins_l = 1'b0;
        step(); step(); step(); #1;
        ntot++; if (ctl !== C_MST) $display("FAIL st_macc: got %b exp %b", ctl, C_MST); else npass++;
        step(); mem_ready = 1'b0; #1;
        ntot++; if (ctl !== C_FWAIT) $display("FAIL st_back_fetch: got %b exp %b", ctl, C_FWAIT); else npass++;
        ntot++; if (instr_cnt !== 16'd4) $display("FAIL st_cnt: got %0d exp 4", instr_cnt); else npass++;
        // Taken branch with link
        mem_ready = 1'b1; ins_type = 3'd2; ins_l = 1'b1; cond_ok = 1'b1;
        step(); mem_ready = 1'b0; step(); #1;
        ntot++; if (ctl !== C_BRL) $display("FAIL br_link: got %b exp %b", ctl, C_BRL); else npass++;
        step(); #1;
        ntot++; if (instr_cnt !== 16'd5) $display("FAIL br_cnt: got %0d exp 5", instr_cnt); else npass++;
        // Not-taken branch still retires
        mem_ready = 1'b1; cond_ok = 1'b0;
        step(); mem_ready = 1'b0; step(); #1;
        ntot++; if (ctl !== C_BRN) $display("FAIL br_not_taken: got %b exp %b", ctl, C_BRN); else npass++;
        step(); #1;
        ntot++; if (instr_cnt !== 16'd6) $display("FAIL br_nt_cnt: got %0d exp 6", instr_cnt); else npass++;
        ins_l = 1'b0;
    endtask

    task automatic test_timeout();
        // Currently on the first FETCH cycle with mem_ready low.
        for (int k = 1; k <= 16; k++) begin
            mem_ready = 1'b0; #1;
            ntot++; if (ctl !== C_FWAIT) $display("FAIL to_wait%0d: got %b exp %b", k, ctl, C_FWAIT); else npass++;
            step();
        end
        #1;
        ntot++; if (ctl !== C_ERR) $display("FAIL to_err: got %b exp %b", ctl, C_ERR); else npass++;
        mem_ready = 1'b1; start = 1'b1; step(); #1;
        ntot++; if (ctl !== C_ERR) $display("FAIL to_err_sticky: got %b exp %b", ctl, C_ERR); else npass++;
        // Ready on the 16th cycle must win over expiry
        do_reset();
        start = 1'b1; step(); start = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            mem_ready = 1'b0; step();
        end
        mem_ready = 1'b1; #1;
        ntot++; if (ctl !== C_FRDY) $display("FAIL to_last_ready: got %b exp %b", ctl, C_FRDY); else npass++;
        step(); mem_ready = 1'b0; #1;
        ntot++; if (ctl !== C_DEC) $display("FAIL to_no_err: got %b exp %b", ctl, C_DEC); else npass++;
    endtask

    task automatic test_halt_reset();
        ins_type = 3'd3;
        step(); #1;
        ntot++; if (ctl !== C_HALT) $display("FAIL halt: got %b exp %b", ctl, C_HALT); else npass++;
        start = 1'b1; mem_ready = 1'b1; step(); step(); step(); #1;
        ntot++; if (ctl !== C_HALT) $display("FAIL halt_sticky: got %b exp %b", ctl, C_HALT); else npass++;
        do_reset();
        #1;
        ntot++; if (ctl !== C_IDLE) $display("FAIL halt_cleared: got %b exp %b", ctl, C_IDLE); else npass++;
        // Reset in the middle of a store access
        start = 1'b1; step(); start = 1'b0;
        mem_ready = 1'b1; ins_type = 3'd1; ins_l = 1'b0;
        step(); mem_ready = 1'b0; step(); step(); #1;
        ntot++; if (ctl !== C_MST) $display("FAIL rst_pre_macc: got %b exp %b", ctl, C_MST); else npass++;
        #2 rst = 1'b1; #1;
        ntot++; if (ctl !== C_IDLE) $display("FAIL rst_async: got %b exp %b", ctl, C_IDLE); else npass++;
        mem_ready = 1'b1; step(); rst = 1'b0; step(); mem_ready = 1'b0; #1;
        ntot++; if (ctl !== C_IDLE) $display("FAIL rst_late_ready: got %b exp %b", ctl, C_IDLE); else npass++;
        ntot++; if (instr_cnt !== 16'd0) $display("FAIL rst_cnt: got %0d exp 0", instr_cnt); else npass++;
    endtask

    task automatic test_saturate();
        do_reset();
        start = 1'b1; ins_type = 3'd0; mem_ready = 1'b1;
        step(); start = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step(); step(); step(); step();
        end
        #1;
        ntot++; if (s_instr_cnt !== 2'd3) $display("FAIL sat_at3: got %0d exp 3", s_instr_cnt); else npass++;
        for (int n = 0; n < 2; n++) begin
            step(); step(); step(); step();
        end
        #1;
        ntot++; if (s_instr_cnt !== 2'd3) $display("FAIL sat_hold: got %0d exp 3", s_instr_cnt); else npass++;
        ntot++; if (instr_cnt !== 16'd5) $display("FAIL sat_wide: got %0d exp 5", instr_cnt); else npass++;
        mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store_branch();
        test_timeout();
        test_halt_reset();
        test_saturate();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d done", npass, ntot);
        $fatal(1, "watchdog");
    end

endmodule
